// File: rtl/tv80_dma_arb.sv
// Arbiter sharing the TV80 memory/IO bus between the CPU core and one DMA master.
// Optional define TV80_ARB_IORQ_EN lets DMA transfers with dma_io=1 use IORQ instead of MREQ.
module tv80_dma_arb #(
    parameter int MAX_BURST = 16,
    parameter int HOLDOFF   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        busrq_n,
    input  logic        busak_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_mreq_n,
    input  logic        cpu_iorq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    output logic [7:0]  cpu_di,
    input  logic        dma_req,
    output logic        dma_gnt,
    input  logic        dma_valid,
    input  logic        dma_we,
    input  logic        dma_io,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ready,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_a,
    output logic [7:0]  mem_do,
    output logic        mem_mreq_n,
    output logic        mem_iorq_n,
    output logic        mem_rd_n,
    output logic        mem_wr_n,
    input  logic [7:0]  mem_di
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

`ifdef TV80_ARB_IORQ_EN
    localparam logic IORQ_EN = 1'b1;
`else
    localparam logic IORQ_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_OWN  = 3'd2,
        S_XFER = 3'd3,
        S_REL  = 3'd4,
        S_HOLD = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          busrq_n_q, busrq_n_d;
    logic          gnt_q, gnt_d;
    logic          ready_q, ready_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          mreq_n_q, mreq_n_d;
    logic          iorq_n_q, iorq_n_d;
    logic          rd_n_q, rd_n_d;
    logic          wr_n_q, wr_n_d;
    logic          xfer_start_s;
    logic          io_eff_s;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abandon in REQ takes priority over the acknowledge
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = dma_req ? S_REQ : S_IDLE;
            S_REQ: begin
                if (!dma_req) begin
                    state_d = S_IDLE;
                end else if (!busak_n) begin
                    state_d = S_OWN;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_OWN: begin
                if (!dma_req || (burst_q == BW'(MAX_BURST))) begin
                    state_d = S_REL;
                end else if (dma_valid) begin
                    state_d = S_XFER;
                end else begin
                    state_d = S_OWN;
                end
            end
            S_XFER: state_d = S_OWN;
            S_REL: begin
                if (!busak_n) begin
                    state_d = S_REL;
                end else if (HOLDOFF == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: state_d = (hold_q <= HW'(1)) ? S_IDLE : S_HOLD;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered handshake, transfer latches and counters derived from the transition
    always_comb begin
        xfer_start_s = (state_q == S_OWN) && (state_d == S_XFER);
        io_eff_s     = dma_io & IORQ_EN;
        busrq_n_d    = !((state_d == S_REQ) || (state_d == S_OWN) || (state_d == S_XFER));
        gnt_d        = (state_d == S_OWN) || (state_d == S_XFER);
        ready_d      = (state_q == S_XFER);
        rdata_d      = ((state_q == S_XFER) && !we_q) ? mem_di : rdata_q;
        mreq_n_d     = !(xfer_start_s && !io_eff_s);
        iorq_n_d     = !(xfer_start_s && io_eff_s);
        rd_n_d       = !(xfer_start_s && !dma_we);
        wr_n_d       = !(xfer_start_s && dma_we);
        if (xfer_start_s) begin
            addr_d  = dma_addr;
            wdata_d = dma_wdata;
            we_d    = dma_we;
        end else begin
            addr_d  = addr_q;
            wdata_d = wdata_q;
            we_d    = we_q;
        end
        if ((state_q == S_REQ) && (state_d == S_OWN)) begin
            burst_d = '0;
        end else if (xfer_start_s && (burst_q != BW'(MAX_BURST))) begin
            burst_d = burst_q + BW'(1);
        end else begin
            burst_d = burst_q;
        end
        if ((state_q == S_REL) && (state_d == S_HOLD)) begin
            hold_d = HW'(HOLDOFF);
        end else if ((state_q == S_HOLD) && (hold_q != '0)) begin
            hold_d = hold_q - HW'(1);
        end else begin
            hold_d = hold_q;
        end
    end

    // Datapath and strobe registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busrq_n_q <= 1'b1;
            gnt_q     <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= 8'h00;
            burst_q   <= '0;
            hold_q    <= '0;
            addr_q    <= 16'h0000;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            mreq_n_q  <= 1'b1;
            iorq_n_q  <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
        end else begin
            busrq_n_q <= busrq_n_d;
            gnt_q     <= gnt_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            burst_q   <= burst_d;
            hold_q    <= hold_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            mreq_n_q  <= mreq_n_d;
            iorq_n_q  <= iorq_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
        end
    end

    // Bus mux: the CPU path stays combinational so the bus reverts the moment the grant drops
    always_comb begin
        if (gnt_q) begin
            mem_a      = addr_q;
            mem_do     = wdata_q;
            mem_mreq_n = mreq_n_q;
            mem_iorq_n = iorq_n_q;
            mem_rd_n   = rd_n_q;
            mem_wr_n   = wr_n_q;
        end else begin
            mem_a      = cpu_a;
            mem_do     = cpu_do;
            mem_mreq_n = cpu_mreq_n;
            mem_iorq_n = cpu_iorq_n;
            mem_rd_n   = cpu_rd_n;
            mem_wr_n   = cpu_wr_n;
        end
    end

    assign cpu_di    = mem_di;
    assign busrq_n   = busrq_n_q;
    assign dma_gnt   = gnt_q;
    assign dma_ready = ready_q;
    assign dma_rdata = rdata_q;

endmodule

// File: tb/tb_tv80_dma_arb.sv
// Directed self-checking bench for tv80_dma_arb with MAX_BURST=4, HOLDOFF=4.
module tb_tv80_dma_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        busrq_n, busak_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do, cpu_di;
    logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n;
    logic        dma_req, dma_gnt, dma_valid, dma_we, dma_io, dma_ready;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic [15:0] mem_a;
    logic [7:0]  mem_do, mem_di;
    logic        mem_mreq_n, mem_iorq_n, mem_rd_n, mem_wr_n;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int n_ready;

    tv80_dma_arb #(.MAX_BURST(4), .HOLDOFF(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .busrq_n(busrq_n), .busak_n(busak_n),
        .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n),
        .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_di(cpu_di),
        .dma_req(dma_req), .dma_gnt(dma_gnt), .dma_valid(dma_valid), .dma_we(dma_we),
        .dma_io(dma_io), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(dma_ready), .dma_rdata(dma_rdata),
        .mem_a(mem_a), .mem_do(mem_do), .mem_mreq_n(mem_mreq_n), .mem_iorq_n(mem_iorq_n),
        .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n), .mem_di(mem_di)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        busak_n    = 1'b1;
        cpu_a      = 16'h1234;
        cpu_do     = 8'h55;
        cpu_mreq_n = 1'b0;
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b0;
        cpu_wr_n   = 1'b1;
        dma_req    = 1'b1;
        dma_valid  = 1'b0;
        dma_we     = 1'b0;
        dma_io     = 1'b0;
        dma_addr   = 16'h0000;
        dma_wdata  = 8'h00;
        mem_di     = 8'h77;

        // reset held with dma_req high
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst_busrq_n", 16'(busrq_n), 16'h1);
            check_val("rst_gnt", 16'(dma_gnt), 16'h0);
        end
        check_val("rst_ready", 16'(dma_ready), 16'h0);
        check_val("rst_rdata", 16'(dma_rdata), 16'h00);
        check_val("rst_mem_a", mem_a, 16'h1234);
        check_val("rst_mem_rd", 16'(mem_rd_n), 16'h0);
        check_val("cpu_di", 16'(cpu_di), 16'h77);
        reset_n = 1'b1;
        tick();
        check_val("req_busrq_n", 16'(busrq_n), 16'h0);

        // core acknowledges 3 cycles after the request
        tick();
        tick();
        check_val("pre_ack_gnt", 16'(dma_gnt), 16'h0);
        busak_n = 1'b0;
        tick();
        check_val("ack_gnt", 16'(dma_gnt), 16'h1);
        check_val("own_mreq", 16'(mem_mreq_n), 16'h1);
        check_val("own_rd", 16'(mem_rd_n), 16'h1);

        // write transfer
        dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 16'h8000; dma_wdata = 8'hA5;
        tick();
        dma_valid = 1'b0;
        check_val("wr_mem_a", mem_a, 16'h8000);
        check_val("wr_mem_do", 16'(mem_do), 16'hA5);
        check_val("wr_mreq", 16'(mem_mreq_n), 16'h0);
        check_val("wr_wr", 16'(mem_wr_n), 16'h0);
        check_val("wr_rd", 16'(mem_rd_n), 16'h1);
        check_val("wr_ready_early", 16'(dma_ready), 16'h0);
        tick();
        check_val("wr_ready", 16'(dma_ready), 16'h1);
        check_val("wr_strobe_off", 16'(mem_wr_n), 16'h1);
        tick();
        check_val("wr_ready_drop", 16'(dma_ready), 16'h0);

        // read capture, then a write that must not disturb it
        mem_di = 8'h3C;
        dma_valid = 1'b1; dma_we = 1'b0; dma_addr = 16'h0100;
        tick();
        dma_valid = 1'b0;
        check_val("rd_mreq", 16'(mem_mreq_n), 16'h0);
        check_val("rd_rd", 16'(mem_rd_n), 16'h0);
        tick();
        check_val("rd_ready", 16'(dma_ready), 16'h1);
        check_val("rd_rdata", 16'(dma_rdata), 16'h3C);
        mem_di = 8'hEE;
        dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 16'h0101; dma_wdata = 8'h11;
        tick();
        dma_valid = 1'b0;
        tick();
        check_val("rd_hold_ready", 16'(dma_ready), 16'h1);
        check_val("rd_hold_rdata", 16'(dma_rdata), 16'h3C);

        // voluntary release
        dma_req = 1'b0;
        tick();
        check_val("rel_gnt", 16'(dma_gnt), 16'h0);
        check_val("rel_busrq_n", 16'(busrq_n), 16'h1);
        check_val("rel_mem_a", mem_a, 16'h1234);
        busak_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // burst limit with dma_valid held high
        dma_req = 1'b1;
        tick();
        check_val("b_busrq_n", 16'(busrq_n), 16'h0);
        busak_n = 1'b0;
        tick();
        check_val("b_gnt", 16'(dma_gnt), 16'h1);
        dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 16'h9000; dma_wdata = 8'h42;
        n_ready = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (dma_ready) n_ready++;
        end
        check_val("b_ready_cnt", 16'(n_ready), 16'd4);
        check_val("b_rel_gnt", 16'(dma_gnt), 16'h0);
        check_val("b_rel_busrq_n", 16'(busrq_n), 16'h1);
        tick();
        dma_valid = 1'b0;
        check_val("b_rel_stay", 16'(dma_gnt), 16'h0);
        busak_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("holdoff_busrq_n", 16'(busrq_n), 16'h1);
        end
        tick();
        check_val("rereq_busrq_n", 16'(busrq_n), 16'h0);

        // abandon: dma_req drops on the same edge the core acknowledges
        dma_req = 1'b0;
        busak_n = 1'b0;
        tick();
        check_val("ab_gnt", 16'(dma_gnt), 16'h0);
        check_val("ab_busrq_n", 16'(busrq_n), 16'h1);
        busak_n = 1'b1;
        tick();
        check_val("ab_gnt2", 16'(dma_gnt), 16'h0);

        // IO read transfer
        dma_req = 1'b1;
        tick();
        busak_n = 1'b0;
        tick();
        mem_di = 8'h5A;
        dma_valid = 1'b1; dma_we = 1'b0; dma_io = 1'b1; dma_addr = 16'h12FE;
        tick();
        dma_valid = 1'b0;
        dma_io = 1'b0;
        check_val("io_mem_a", mem_a, 16'h12FE);
        check_val("io_rd", 16'(mem_rd_n), 16'h0);
`ifdef TV80_ARB_IORQ_EN
        check_val("io_iorq", 16'(mem_iorq_n), 16'h0);
        check_val("io_mreq", 16'(mem_mreq_n), 16'h1);
`else
        check_val("io_iorq", 16'(mem_iorq_n), 16'h1);
        check_val("io_mreq", 16'(mem_mreq_n), 16'h0);
`endif
        tick();
        check_val("io_rdata", 16'(dma_rdata), 16'h5A);
        dma_req = 1'b0;
        tick();
        busak_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // asynchronous reset in the middle of a write transfer
        dma_req = 1'b1;
        tick();
        busak_n = 1'b0;
        tick();
        dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 16'h4444; dma_wdata = 8'h99;
        tick();
        dma_valid = 1'b0;
        check_val("ar_xfer_wr", 16'(mem_wr_n), 16'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("ar_gnt", 16'(dma_gnt), 16'h0);
        check_val("ar_wr", 16'(mem_wr_n), 16'h1);
        check_val("ar_mem_a", mem_a, 16'h1234);
        check_val("ar_busrq_n", 16'(busrq_n), 16'h1);
        tick();
        check_val("ar_ready", 16'(dma_ready), 16'h0);
        check_val("ar_rdata", 16'(dma_rdata), 16'h00);
        reset_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
